// File: rtl/tage_spec_ghr.sv
// rtl/tage_spec_ghr.sv - speculative global history with checkpoint/recover and folded indices
module tage_spec_ghr #(
    parameter int GHR_LEN    = 64,
    parameter int NUM_TABLES = 4,
    parameter int L_MIN      = 4,
    parameter int FOLD_W     = 8,
    parameter int CKPT_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pred_valid,
    input  logic                            pred_taken,
    output logic                            pred_ready,
    output logic [$clog2(CKPT_DEPTH)-1:0]   pred_tag,
    input  logic                            commit_valid,
    input  logic                            recover_valid,
    input  logic [$clog2(CKPT_DEPTH)-1:0]   recover_tag,
    input  logic                            recover_taken,
    output logic                            recover_err,
    output logic [GHR_LEN-1:0]              spec_ghr,
    output logic [NUM_TABLES*FOLD_W-1:0]    fold_idx,
    output logic [$clog2(CKPT_DEPTH):0]     ckpt_count
);
    localparam int TW = $clog2(CKPT_DEPTH);
    localparam int CW = TW + 1;

    logic [GHR_LEN-1:0] ghr_q, ghr_d;
    logic [TW-1:0]      head_q, head_d;
    logic [TW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               err_q, err_d;
    logic [GHR_LEN-1:0] ckpt_q [CKPT_DEPTH];

    logic               push;
    logic               commit;
    logic [TW-1:0]      rec_dist;
    logic               rec_live;

    // A recovery owns the cycle, so pushes are held off while one is presented.
    assign pred_ready = !rst && (count_q != CW'(CKPT_DEPTH)) && !recover_valid;
    assign push       = pred_valid && pred_ready;
    assign commit     = commit_valid && (count_q != '0);
    // Distance from the oldest live slot; modular wrap comes free from TW-bit arithmetic.
    assign rec_dist   = recover_tag - head_q;
    assign rec_live   = {1'b0, rec_dist} < count_q;

    assign pred_tag    = tail_q;
    assign spec_ghr    = ghr_q;
    assign ckpt_count  = count_q;
    assign recover_err = err_q;

    // Next-state for history, ring pointers, occupancy and the error pulse.
    always_comb begin
        ghr_d   = ghr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = 1'b0;
        if (commit) begin
            head_d = head_q + TW'(1);
        end
        if (recover_valid) begin
            if (rec_live) begin
                // The mispredicted branch stays in flight; everything younger is dropped.
                ghr_d   = {ckpt_q[recover_tag][GHR_LEN-2:0], recover_taken};
                tail_d  = recover_tag + TW'(1);
                count_d = {1'b0, rec_dist} + CW'(1) - CW'(commit);
            end else begin
                err_d   = 1'b1;
                count_d = count_q - CW'(commit);
            end
        end else begin
            if (push) begin
                ghr_d  = {ghr_q[GHR_LEN-2:0], pred_taken};
                tail_d = tail_q + TW'(1);
            end
            count_d = count_q + CW'(push) - CW'(commit);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ghr_q   <= ghr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Checkpoint store: snapshot of the history before each accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < CKPT_DEPTH; s++) begin
                ckpt_q[s] <= '0;
            end
        end else if (push) begin
            ckpt_q[tail_q] <= ghr_q;
        end
    end

    // Per-table folding: XOR of FOLD_W-wide chunks of the youngest L_i bits.
    for (genvar i = 0; i < NUM_TABLES; i++) begin : g_fold
        localparam int LI = L_MIN << i;
        localparam int NC = (LI + FOLD_W - 1) / FOLD_W;
        logic [NC*FOLD_W-1:0] padded;
        logic [FOLD_W-1:0]    acc;

        // Zero-pad the truncated history, then reduce chunk by chunk.
        always_comb begin
            padded         = '0;
            padded[LI-1:0] = ghr_q[LI-1:0];
            acc            = '0;
            for (int k = 0; k < NC; k++) begin
                acc = acc ^ padded[k*FOLD_W +: FOLD_W];
            end
        end

        assign fold_idx[i*FOLD_W +: FOLD_W] = acc;
    end
endmodule
